// File: rtl/discrete_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed 16x16 multiplier between NUM_REQ audio stages.
// Define DISCRETE_MULT_SAT_EN to saturate the scaled product instead of wrapping it to 16 bits.
module discrete_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 2,
    parameter int RESULT_SHIFT = 14
) (
    input  logic                      clk,
    input  logic                      I_RSTn,
    input  logic                      audio_clk_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [16*NUM_REQ-1:0]     op_a,
    input  logic [16*NUM_REQ-1:0]     op_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic signed [15:0]        result,
    output logic [NUM_REQ-1:0]        overrun,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic logic signed [15:0] narrow(input logic signed [31:0] v);
`ifdef DISCRETE_MULT_SAT_EN
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
`else
        return v[15:0];
`endif
    endfunction

    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_gnt, r_ack, r_outst, r_overrun;
    logic [NUM_REQ-1:0] w_elig, w_gnt_next;
    logic               w_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W:0]     w_scan;

    logic               r_vld_p0;
    logic [IDX_W-1:0]   r_tag_p0;
    logic signed [15:0] r_a_p0, r_b_p0;
    logic signed [31:0] w_prod_p0, w_shift_p0;
    logic signed [15:0] w_val_p0;

    logic               w_fin_vld;
    logic [IDX_W-1:0]   w_fin_tag;
    logic signed [15:0] w_fin_val;
    logic signed [15:0] r_result;
    logic               w_busy_tail;

    // A requester whose ack is on the bus this cycle is already eligible again.
    always_comb begin
        w_elig     = req & ~(r_outst & ~r_ack);
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_next = '0;
        w_scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(NUM_REQ))
                w_scan = w_scan - (IDX_W+1)'(NUM_REQ);
            if (!w_found && w_elig[w_scan[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[IDX_W-1:0];
            end
        end
        if (w_found)
            w_gnt_next[w_gnt_idx] = 1'b1;
    end

    // Arbitration, outstanding tracking and overrun flags
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_outst   <= '0;
            r_overrun <= '0;
            r_vld_p0  <= 1'b0;
            r_tag_p0  <= '0;
        end else begin
            r_gnt    <= w_gnt_next;
            r_outst  <= (r_outst & ~r_ack) | w_gnt_next;
            r_vld_p0 <= w_found;
            if (w_found) begin
                r_tag_p0 <= w_gnt_idx;
                r_ptr    <= (w_gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + IDX_W'(1);
            end
            if (audio_clk_en)
                r_overrun <= r_overrun | (req & ~(r_gnt | w_gnt_next));
        end
    end

    // Stage p0: operand capture on the grant edge
    always_ff @(posedge clk) begin
        if (w_found) begin
            r_a_p0 <= op_a[{w_gnt_idx, 4'b0000} +: 16];
            r_b_p0 <= op_b[{w_gnt_idx, 4'b0000} +: 16];
        end
    end

    always_comb begin
        w_prod_p0  = 32'(r_a_p0) * 32'(r_b_p0);
        w_shift_p0 = w_prod_p0 >>> RESULT_SHIFT;
        w_val_p0   = narrow(w_shift_p0);
    end

    generate
        if (MULT_LATENCY == 1) begin : g_direct
            assign w_fin_vld   = r_vld_p0;
            assign w_fin_tag   = r_tag_p0;
            assign w_fin_val   = w_val_p0;
            assign w_busy_tail = 1'b0;
        end else begin : g_delay
            logic               r_vld_pd [MULT_LATENCY-1];
            logic [IDX_W-1:0]   r_tag_pd [MULT_LATENCY-1];
            logic signed [15:0] r_val_pd [MULT_LATENCY-1];

            // Stages p1..: delay line between p0 and the output register
            always_ff @(posedge clk or negedge I_RSTn) begin
                if (!I_RSTn) begin
                    for (int k = 0; k < MULT_LATENCY-1; k++)
                        r_vld_pd[k] <= 1'b0;
                end else begin
                    r_vld_pd[0] <= r_vld_p0;
                    for (int k = 1; k < MULT_LATENCY-1; k++)
                        r_vld_pd[k] <= r_vld_pd[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (r_vld_p0) begin
                    r_tag_pd[0] <= r_tag_p0;
                    r_val_pd[0] <= w_val_p0;
                end
                for (int k = 1; k < MULT_LATENCY-1; k++) begin
                    if (r_vld_pd[k-1]) begin
                        r_tag_pd[k] <= r_tag_pd[k-1];
                        r_val_pd[k] <= r_val_pd[k-1];
                    end
                end
            end

            always_comb begin
                w_busy_tail = 1'b0;
                for (int k = 0; k < MULT_LATENCY-1; k++)
                    w_busy_tail = w_busy_tail | r_vld_pd[k];
            end

            assign w_fin_vld = r_vld_pd[MULT_LATENCY-2];
            assign w_fin_tag = r_tag_pd[MULT_LATENCY-2];
            assign w_fin_val = r_val_pd[MULT_LATENCY-2];
        end
    endgenerate

    // Output stage: ack pulse and held result
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_ack    <= '0;
            r_result <= '0;
        end else begin
            r_ack <= '0;
            if (w_fin_vld) begin
                r_ack[w_fin_tag] <= 1'b1;
                r_result         <= w_fin_val;
            end
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign result  = r_result;
    assign overrun = r_overrun;
    assign busy    = r_vld_p0 | w_busy_tail;
endmodule

// File: tb/tb_discrete_mult_arbiter.sv
// Directed bench for discrete_mult_arbiter at default parameters (4 requesters, latency 2, shift 14).
module tb_discrete_mult_arbiter;
    logic               clk;
    logic               I_RSTn;
    logic               audio_clk_en;
    logic [3:0]         req;
    logic [63:0]        op_a;
    logic [63:0]        op_b;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic signed [15:0] result;
    logic [3:0]         overrun;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    // 30000*30000>>>14 = 54931; -32768*-32768>>>14 = 65536; -32768*32767>>>14 = -65534
`ifdef DISCRETE_MULT_SAT_EN
    localparam logic signed [15:0] EXP_B2B     = 16'sh7FFF;
    localparam logic signed [15:0] EXP_SAT_POS = 16'sh7FFF;
    localparam logic signed [15:0] EXP_SAT_NEG = 16'sh8000;
`else
    localparam logic signed [15:0] EXP_B2B     = -16'sd10605;
    localparam logic signed [15:0] EXP_SAT_POS = 16'sd0;
    localparam logic signed [15:0] EXP_SAT_NEG = 16'sd2;
`endif

    discrete_mult_arbiter dut (
        .clk          (clk),
        .I_RSTn       (I_RSTn),
        .audio_clk_en (audio_clk_en),
        .req          (req),
        .op_a         (op_a),
        .op_b         (op_b),
        .gnt          (gnt),
        .ack          (ack),
        .result       (result),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic signed [15:0] a, input logic signed [15:0] b);
        op_a[idx*16 +: 16] = a;
        op_b[idx*16 +: 16] = b;
    endtask

    task automatic do_reset();
        req = '0;
        audio_clk_en = 1'b0;
        I_RSTn = 1'b0;
        tick();
        tick();
        I_RSTn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        I_RSTn = 1'b0;
        audio_clk_en = 1'b0;
        req = '0;
        op_a = '0;
        op_b = '0;
        tick();
        tick();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_tests++; if (result !== 16'sd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
        n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0000", overrun); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        I_RSTn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_ops(0, 16'sd16384, 16'sd8192);
        req = 4'b0001;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t0: got %b expected 1", busy); end
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_t0: got %b expected 0000", ack); end
        req = 4'b0000;
        tick();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_t1: got %b expected 0000", gnt); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %b expected 1", busy); end
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_t1: got %b expected 0000", ack); end
        tick();
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", ack); end
        n_tests++; if (result !== 16'sd8192) begin n_fail++; $display("FAIL single_result: got %0d expected 8192", result); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t2: got %b expected 0", busy); end
        tick();
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_t3: got %b expected 0000", ack); end
        n_tests++; if (result !== 16'sd8192) begin n_fail++; $display("FAIL single_result_hold: got %0d expected 8192", result); end
    endtask

    // Pointer is 1 here after the single grant to requester 0.
    task automatic test_back_to_back();
        set_ops(1, -16'sd16384, 16'sd12000);
        set_ops(2, 16'sd30000, 16'sd30000);
        req = 4'b0110;
        tick();
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_gnt1: got %b expected 0010", gnt); end
        req = 4'b0100;
        tick();
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL b2b_gnt2: got %b expected 0100", gnt); end
        req = 4'b0000;
        tick();
        n_tests++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL b2b_ack1: got %b expected 0010", ack); end
        n_tests++; if (result !== -16'sd12000) begin n_fail++; $display("FAIL b2b_result1: got %0d expected -12000", result); end
        tick();
        n_tests++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL b2b_ack2: got %b expected 0100", ack); end
        n_tests++; if (result !== EXP_B2B) begin n_fail++; $display("FAIL b2b_result2: got %0d expected %0d", result, EXP_B2B); end
        tick();
    endtask

    // Pointer is 3 here.
    task automatic test_saturation();
        set_ops(3, -16'sd32768, -16'sd32768);
        req = 4'b1000;
        tick();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL sat_gnt3: got %b expected 1000", gnt); end
        req = 4'b0000;
        tick();
        tick();
        n_tests++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL sat_ack3: got %b expected 1000", ack); end
        n_tests++; if (result !== EXP_SAT_POS) begin n_fail++; $display("FAIL sat_pos_result: got %0d expected %0d", result, EXP_SAT_POS); end
        set_ops(0, -16'sd32768, 16'sd32767);
        req = 4'b0001;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL sat_gnt0: got %b expected 0001", gnt); end
        req = 4'b0000;
        tick();
        tick();
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL sat_ack0: got %b expected 0001", ack); end
        n_tests++; if (result !== EXP_SAT_NEG) begin n_fail++; $display("FAIL sat_neg_result: got %0d expected %0d", result, EXP_SAT_NEG); end
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        logic [3:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'sd16384);
        req = 4'b1111;
        for (int k = 0; k < 64; k++) begin
            tick();
            exp_g = 4'b0001 << (k % 4);
            exp_a = (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000;
            n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b expected %b", k, gnt, exp_g); end
            n_tests++; if (ack !== exp_a) begin n_fail++; $display("FAIL fair_ack[%0d]: got %b expected %b", k, ack, exp_a); end
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_overrun();
        do_reset();
        req = 4'b1001;
        audio_clk_en = 1'b1;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ovr_gnt0: got %b expected 0001", gnt); end
        n_tests++; if (overrun !== 4'b1000) begin n_fail++; $display("FAIL ovr_set: got %b expected 1000", overrun); end
        audio_clk_en = 1'b0;
        req = 4'b1000;
        tick();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL ovr_gnt3: got %b expected 1000", gnt); end
        req = 4'b0000;
        repeat (3) tick();
        n_tests++; if (overrun !== 4'b1000) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1000", overrun); end

        do_reset();
        req = 4'b1000;
        audio_clk_en = 1'b1;
        tick();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL ovr_coinc_gnt: got %b expected 1000", gnt); end
        n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_coinc_decide: got %b expected 0000", overrun); end
        tick();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ovr_no_regrant: got %b expected 0000", gnt); end
        n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_coinc_visible: got %b expected 0000", overrun); end
        audio_clk_en = 1'b0;
        req = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_ops(0, 16'sd1000, 16'sd1000);
        req = 4'b0001;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_gnt: got %b expected 0001", gnt); end
        req = 4'b0000;
        tick();
        I_RSTn = 1'b0;
        #1;
        n_tests++; if ({gnt, ack, overrun, busy} !== 13'd0) begin n_fail++; $display("FAIL mid_outputs: got gnt=%b ack=%b ovr=%b busy=%b expected all 0", gnt, ack, overrun, busy); end
        n_tests++; if (result !== 16'sd0) begin n_fail++; $display("FAIL mid_result: got %0d expected 0", result); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL mid_ack_in_reset[%0d]: got %b expected 0000", k, ack); end
        end
        I_RSTn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL mid_ack_after[%0d]: got %b expected 0000", k, ack); end
        end
        set_ops(3, 16'sd1, 16'sd1);
        req = 4'b1001;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr0_gnt: got %b expected 0001", gnt); end
        req = 4'b1000;
        tick();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_next_gnt: got %b expected 1000", gnt); end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_fairness();
        test_overrun();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
